// File: rtl/sram_stream_reader_if.sv
// SRAM read port and downstream valid/ready stream of the vector SRAM reader.
// The master modport is the reader side; the slave modport is the SRAM and
// the stream consumer.
interface sram_stream_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128
);
  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output sram_cen, sram_wen, sram_a, out_valid, out_data, out_last,
    input  sram_q, out_ready
  );

  modport slave (
    input  sram_cen, sram_wen, sram_a, out_valid, out_data, out_last,
    output sram_q, out_ready
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Read-side sequencer for the 2048x128 vector SRAM. Issues a run of
// single-word reads, absorbs the one-cycle read latency and streams the
// words out through a small shift FIFO whose head register is out_data.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; count=0 only produces a done pulse
// RUN   | reads still to issue; issue limited by free buffer space
// DRAIN | all reads issued; waiting for the last word to be taken
module sram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      count,
  output logic                 busy,
  output logic                 done,
  sram_stream_reader_if.master bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W:0]   remaining_q, remaining_n;
  logic [ADDR_W:0]   to_deliver_q, to_deliver_n;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic [DATA_W-1:0] fifo_n [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_n;
  logic              out_valid_q, out_last_q;
  logic              busy_q, done_q, done_n;
  logic              pop, issue;
  logic [OCC_W:0]    pending;
  logic [OCC_W:0]    wr_idx;

  // Words already owed to the buffer after this cycle's pop decide whether
  // another read fits; this is what keeps a push off a full buffer.
  assign pop     = out_valid_q & bus.out_ready;
  assign pending = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
  assign issue   = (state_q == RUN) && (remaining_q != '0) &&
                   (pending < (OCC_W+1)'(DEPTH));
  assign wr_idx  = {1'b0, occ_q} - (OCC_W+1)'(pop);

  assign bus.sram_cen  = ~issue;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_a    = issue ? addr_q : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = fifo_q[0];
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Next state, read address and run counters.
  always_comb begin
    state_n      = state_q;
    addr_n       = addr_q;
    remaining_n  = remaining_q;
    to_deliver_n = to_deliver_q;
    done_n       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_n       = base_addr;
            remaining_n  = count;
            to_deliver_n = count;
            state_n      = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (remaining_q == (ADDR_W+1)'(1))) state_n = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last_q) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) begin
      addr_n      = addr_q + ADDR_W'(1);
      remaining_n = remaining_q - (ADDR_W+1)'(1);
    end
    if (pop) to_deliver_n = to_deliver_q - (ADDR_W+1)'(1);
  end

  // Shift FIFO: pop shifts toward the head, the returning word lands behind
  // the last occupied entry so out_data stays a plain register.
  always_comb begin
    fifo_n = fifo_q;
    occ_n  = occ_q + OCC_W'(inflight_q) - OCC_W'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) fifo_n[i] = fifo_q[i+1];
      fifo_n[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (inflight_q && ((OCC_W+1)'(i) == wr_idx)) fifo_n[i] = bus.sram_q;
    end
  end

  // State, counters, buffer and registered stream/status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      to_deliver_q <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      addr_q       <= addr_n;
      remaining_q  <= remaining_n;
      to_deliver_q <= to_deliver_n;
      inflight_q   <= issue;
      occ_q        <= occ_n;
      fifo_q       <= fifo_n;
      out_valid_q  <= (occ_n != '0);
      out_last_q   <= (occ_n != '0) && (to_deliver_n == (ADDR_W+1)'(1));
      busy_q       <= (state_n != IDLE);
      done_q       <= done_n;
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model with one-cycle latency, random
// contents and backpressure, checked against an expected word list per run.
module tb_sram_stream_reader;
  localparam int AW = 11;
  localparam int DW = 128;
  localparam int NW = 2048;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;

  sram_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [NW];

  // SRAM: address registered on the edge, data valid the following cycle.
  always @(posedge CLK) if (!bus.sram_cen) bus.sram_q <= mem[bus.sram_a];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cen"},   bus.sram_cen,  1);
    check_val({tag, "_a"},     bus.sram_a,    0);
    check_val({tag, "_wen"},   bus.sram_wen,  1);
    check_val({tag, "_valid"}, bus.out_valid, 0);
    check_val({tag, "_last"},  bus.out_last,  0);
    check_val({tag, "_data"},  bus.out_data,  0);
    check_val({tag, "_busy"},  busy,          0);
    check_val({tag, "_done"},  done,          0);
  endtask

  function automatic logic ready_at(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b100101;
    case (mode)
      0:       return 1'b1;
      1:       return pat[5 - (cyc % 6)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One run: cycle 0 is the start cycle, outputs sampled mid-cycle.
  task automatic run_job(input int base, input int n, input int rmode,
                         input bit timing, input bit mid_start);
    logic [DW-1:0] expq [$];
    int issued = 0, popped = 0, dones = 0, cyc = 0;
    int done_cyc = -1, first_v = -1, last_pop = -1;
    bit stalled = 0, pop;
    logic [DW-1:0] hold_d;
    logic hold_l;
    for (int i = 0; i < n; i++) expq.push_back(mem[(base + i) % NW]);
    @(negedge CLK);
    start = 1'b1;
    base_addr = AW'(base);
    count = (AW+1)'(n);
    bus.out_ready = ready_at(rmode, 0);
    while (cyc < n * 4 + 40 && !(dones > 0 && cyc >= done_cyc + 2)) begin
      @(posedge CLK);
      cyc++;
      #1;
      start = (mid_start && cyc == 3);
      if (start) begin
        base_addr = AW'(base + 100);
        count = (AW+1)'(3);
      end
      bus.out_ready = ready_at(rmode, cyc);
      @(negedge CLK);
      pop = bus.out_valid && bus.out_ready;
      if (stalled) begin
        check_val("hold_valid", bus.out_valid, 1);
        check_val("hold_data", bus.out_data, hold_d);
        check_val("hold_last", bus.out_last, hold_l);
      end
      if (!bus.sram_cen) begin
        check_val("rd_addr", bus.sram_a, (base + issued) % NW);
        check_val("rd_in_range", issued < n, 1);
        check_val("rd_room", (issued - popped - int'(pop)) < 2, 1);
        issued++;
      end
      if (bus.out_valid) begin
        check_val("valid_in_run", n != 0, 1);
        check_val("last", bus.out_last, popped == n - 1);
        if (first_v < 0) first_v = cyc;
      end
      if (pop) begin
        if (popped < n) check_val("data", bus.out_data, expq[popped]);
        else check_val("extra_word", 1, 0);
        popped++;
        last_pop = cyc;
      end
      stalled = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
      check_val("wen", bus.sram_wen, 1);
      check_val("busy", busy, (n != 0) && (dones == 0) && !done);
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (timing && cyc == 1 && n != 0) begin
        check_val("c1_cen", bus.sram_cen, 0);
        check_val("c1_addr", bus.sram_a, base % NW);
      end
    end
    if (dones == 0) check_val("timeout", 1, 0);
    check_val("done_count", dones, 1);
    check_val("words", popped, n);
    if (timing) begin
      if (n != 0) begin
        check_val("first_valid_cyc", first_v, 3);
        check_val("last_pop_cyc", last_pop, n + 2);
        check_val("done_cyc", done_cyc, n + 3);
      end else begin
        check_val("zero_done_cyc", done_cyc, 1);
        check_val("zero_reads", issued, 0);
        check_val("zero_valid", first_v, -1);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    RST_N = 1'b1;

    run_job(5, 4, 0, 1, 0);
    run_job(2046, 4, 0, 1, 0);
    run_job(int'($urandom_range(0, NW - 1)), 6, 1, 0, 0);
    run_job(int'($urandom_range(0, NW - 1)), 0, 0, 1, 0);
    run_job(int'($urandom_range(0, NW - 1)), 8, 0, 1, 1);

    // Reset in cycle 4 of a count=10 run.
    @(negedge CLK);
    start = 1'b1;
    base_addr = AW'($urandom_range(0, NW - 1));
    count = (AW+1)'(10);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    run_job(int'($urandom_range(0, NW - 1)), 2, 0, 1, 0);

    for (int j = 0; j < 12; j++)
      run_job(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 40)), 2, 0, 0);

    run_job(0, 2048, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
